l15_data_ram_arbiter: RTL and testbench
=======================================

L15_DATA_RAM_ARBITER -- requirements
Module: l15_data_ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, data RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, data RAM word address width.
REQ-003 SHALL have parameter MAX_WAIT, default 8, fetch starvation limit in cycles (1..255).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports fetch_req / fetch_gnt  input / output  1 / 1  fetch read request and grant.
REQ-007 SHALL have port fetch_addr  input  ADDR_WIDTH  fetch read address.
REQ-008 SHALL have ports fetch_rvalid / fetch_rdata  output / output  1 / DATA_WIDTH  read response.
REQ-009 SHALL have ports refill_req / refill_gnt / refill_last  input / output / input  1 each  refill write beat handshake; last marks final beat of a line.
REQ-010 SHALL have ports refill_addr / refill_wdata / refill_be  input  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  refill write beat.
REQ-011 SHALL have ports ram_req / ram_write / ram_addr / ram_wdata / ram_be  output  1 / 1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  single-port RAM command.
REQ-012 SHALL have port ram_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after a read command.

Function
REQ-013 SHALL grant at most one requester per cycle; a grant is combinational in the request cycle and drives ram_req=1 that cycle.
REQ-014 SHALL drive ram_write=1, ram_addr/wdata/be from refill on refill_gnt; ram_write=0, ram_addr=fetch_addr, ram_be=0 on fetch_gnt; ram_req=0 with no grant.
REQ-015 SHALL assert fetch_rvalid exactly one cycle after fetch_gnt, with fetch_rdata=ram_rdata; no backpressure on responses.
REQ-016 SHALL implement FSM states IDLE and BURST.
REQ-017 IDLE: refill has priority over fetch unless the aging override (REQ-021) is active; granted refill beat with refill_last=0 -> BURST; with refill_last=1 -> stay IDLE.
REQ-018 BURST: only refill may be granted; fetch_gnt=0 regardless of fetch_req; granted beat with refill_last=1 -> IDLE.
REQ-019 BURST with refill_req=0: SHALL stay in BURST, ram_req=0 (gaps between beats do not release the lock).
REQ-020 Requester SHALL hold req, addr and data stable until granted; the block does not register request payloads.

Reset
REQ-022 On rst_n=0 at a clock edge: state=IDLE, fetch_rvalid=0, aging counter=0; grants and ram_req follow REQ-013/014 combinationally from IDLE.
REQ-023 Reset asserted mid-burst SHALL abandon the burst; no partial-line recovery is performed.
REQ-024 fetch_rdata SHALL be ram_rdata passthrough and has no reset value; consumers qualify with fetch_rvalid.

Configuration
REQ-025 Macro L15_DATA_ARB_AGING_EN SHALL compile in the fetch aging logic.
REQ-021 With L15_DATA_ARB_AGING_EN: an 8-bit counter increments each cycle fetch_req=1 and fetch_gnt=0, saturates at MAX_WAIT, clears on fetch_gnt; counter==MAX_WAIT in IDLE grants fetch over refill; BURST is never broken.
REQ-026 Without L15_DATA_ARB_AGING_EN: no counter exists; refill has strict priority in IDLE.

Verification
REQ-027 Fetch only: fetch_req=1, addr=0x05 -> fetch_gnt same cycle, ram_write=0, ram_addr=0x05; next cycle fetch_rvalid=1, fetch_rdata=ram_rdata.
REQ-028 Simultaneous req in IDLE, refill_last=1 -> refill_gnt=1, fetch_gnt=0; next cycle (refill_req=0) fetch_gnt=1.
REQ-029 4-beat burst with a 2-cycle gap after beat 2 and fetch_req held high -> fetch_gnt=0 through beat 4, ram_req=0 during gap; fetch granted the cycle after last beat.
REQ-030 AGING_EN, MAX_WAIT=3, back-to-back single-beat refills and fetch_req held -> fetch granted on 4th cycle of waiting; counter returns to 0.
REQ-031 rst_n=0 during beat 2 of a burst -> next cycle state IDLE, fetch_rvalid=0; pending fetch granted if refill_req=0.

Source files
------------

// File: rtl/l15_data_ram_arbiter.sv
// rtl/l15_data_ram_arbiter.sv - single-port L1.5 data RAM arbiter, refill bursts lock out fetch reads
// Optional fetch aging compiled in with `define L15_DATA_ARB_AGING_EN
module l15_data_ram_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6,
    parameter int MAX_WAIT   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_req,
    output logic                    fetch_gnt,
    input  logic [ADDR_WIDTH-1:0]   fetch_addr,
    output logic                    fetch_rvalid,
    output logic [DATA_WIDTH-1:0]   fetch_rdata,
    input  logic                    refill_req,
    output logic                    refill_gnt,
    input  logic                    refill_last,
    input  logic [ADDR_WIDTH-1:0]   refill_addr,
    input  logic [DATA_WIDTH-1:0]   refill_wdata,
    input  logic [DATA_WIDTH/8-1:0] refill_be,
    output logic                    ram_req,
    output logic                    ram_write,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [DATA_WIDTH/8-1:0] ram_be,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   fetch_starved;

`ifdef L15_DATA_ARB_AGING_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (fetch_gnt) begin
            wait_cnt <= 8'd0;
        end else if (fetch_req && (wait_cnt != 8'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign fetch_starved = (wait_cnt == 8'(MAX_WAIT));
`else
    assign fetch_starved = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            fetch_rvalid <= 1'b0;
        end else begin
            state        <= state_nxt;
            fetch_rvalid <= fetch_gnt;
        end
    end

    // An open burst is never interrupted, even by a starved fetch.
    always_comb begin
        state_nxt  = state;
        fetch_gnt  = 1'b0;
        refill_gnt = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req && fetch_starved) begin
                    fetch_gnt = 1'b1;
                end else if (refill_req) begin
                    refill_gnt = 1'b1;
                    if (!refill_last) state_nxt = BURST;
                end else if (fetch_req) begin
                    fetch_gnt = 1'b1;
                end
            end
            BURST: begin
                if (refill_req) begin
                    refill_gnt = 1'b1;
                    if (refill_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_req     = fetch_gnt | refill_gnt;
    assign ram_write   = refill_gnt;
    assign ram_addr    = refill_gnt ? refill_addr : fetch_addr;
    assign ram_wdata   = refill_wdata;
    assign ram_be      = refill_gnt ? refill_be : '0;
    assign fetch_rdata = ram_rdata;

endmodule

// File: tb/tb_l15_data_ram_arbiter.sv
// tb/tb_l15_data_ram_arbiter.sv - directed self-checking bench for l15_data_ram_arbiter
module tb_l15_data_ram_arbiter;
    localparam int DW = 128;
    localparam int AW = 6;
`ifdef L15_DATA_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_req, fetch_gnt, fetch_rvalid;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] fetch_rdata;
    logic          refill_req, refill_gnt, refill_last;
    logic [AW-1:0] refill_addr;
    logic [DW-1:0] refill_wdata;
    logic [DW/8-1:0] refill_be;
    logic          ram_req, ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [DW/8-1:0] ram_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l15_data_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_addr(fetch_addr),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .refill_req(refill_req), .refill_gnt(refill_gnt), .refill_last(refill_last),
        .refill_addr(refill_addr), .refill_wdata(refill_wdata), .refill_be(refill_be),
        .ram_req(ram_req), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive new inputs just after a rising edge; outputs are then checked at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic refill_beat(input logic req, input logic last, input logic [AW-1:0] addr);
        refill_req  = req;
        refill_last = last;
        refill_addr = addr;
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0;
        refill_req = 1'b0; refill_last = 1'b0; refill_addr = '0;
        refill_wdata = '0; refill_be = '0; ram_rdata = '0;

        // reset
        next_cycle();
        @(negedge clk);
        check("rst_rvalid", fetch_rvalid, 0);
        check("rst_ram_req", ram_req, 0);
        check("rst_fetch_gnt", fetch_gnt, 0);
        check("rst_refill_gnt", refill_gnt, 0);

        // fetch only
        next_cycle();
        rst_n = 1'b1;
        fetch_req = 1'b1; fetch_addr = 6'h05;
        @(negedge clk);
        check("f_gnt", fetch_gnt, 1);
        check("f_ram_req", ram_req, 1);
        check("f_ram_write", ram_write, 0);
        check("f_ram_addr", ram_addr, 6'h05);
        check("f_ram_be", ram_be, 0);
        check("f_refill_gnt", refill_gnt, 0);
        next_cycle();
        fetch_req = 1'b0;
        ram_rdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
        @(negedge clk);
        check("f_rvalid", fetch_rvalid, 1);
        check("f_rdata", fetch_rdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C);
        check("f_idle_ram_req", ram_req, 0);
        next_cycle();
        @(negedge clk);
        check("f_rvalid_drop", fetch_rvalid, 0);

        // simultaneous requests, single-beat refill wins
        next_cycle();
        fetch_req = 1'b1; fetch_addr = 6'h22;
        refill_beat(1'b1, 1'b1, 6'h09);
        refill_wdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        refill_be = 16'hF0F0;
        @(negedge clk);
        check("s_refill_gnt", refill_gnt, 1);
        check("s_fetch_gnt", fetch_gnt, 0);
        check("s_ram_write", ram_write, 1);
        check("s_ram_addr", ram_addr, 6'h09);
        check("s_ram_be", ram_be, 16'hF0F0);
        check("s_ram_wdata", ram_wdata, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        next_cycle();
        refill_beat(1'b0, 1'b0, 6'h00);
        @(negedge clk);
        check("s_fetch_gnt2", fetch_gnt, 1);
        check("s_ram_addr2", ram_addr, 6'h22);
        check("s_rvalid_after_write", fetch_rvalid, 0);
        next_cycle();
        fetch_req = 1'b0;
        @(negedge clk);
        check("s_rvalid", fetch_rvalid, 1);

        // 4-beat burst with a 2-cycle gap, fetch held
        next_cycle();
        fetch_req = 1'b1; fetch_addr = 6'h30;
        refill_beat(1'b1, 1'b0, 6'h10);
        @(negedge clk);
        check("b1_refill_gnt", refill_gnt, 1);
        check("b1_fetch_gnt", fetch_gnt, 0);
        next_cycle();
        refill_beat(1'b1, 1'b0, 6'h11);
        @(negedge clk);
        check("b2_refill_gnt", refill_gnt, 1);
        check("b2_ram_addr", ram_addr, 6'h11);
        check("b2_fetch_gnt", fetch_gnt, 0);
        for (int g = 0; g < 2; g++) begin
            next_cycle();
            refill_beat(1'b0, 1'b0, 6'h00);
            @(negedge clk);
            check("gap_ram_req", ram_req, 0);
            check("gap_fetch_gnt", fetch_gnt, 0);
        end
        next_cycle();
        refill_beat(1'b1, 1'b0, 6'h12);
        @(negedge clk);
        check("b3_refill_gnt", refill_gnt, 1);
        check("b3_fetch_gnt", fetch_gnt, 0);
        next_cycle();
        refill_beat(1'b1, 1'b1, 6'h13);
        @(negedge clk);
        check("b4_refill_gnt", refill_gnt, 1);
        check("b4_fetch_gnt", fetch_gnt, 0);
        check("b4_ram_addr", ram_addr, 6'h13);
        next_cycle();
        refill_beat(1'b0, 1'b0, 6'h00);
        @(negedge clk);
        check("b_post_fetch_gnt", fetch_gnt, 1);
        check("b_post_ram_addr", ram_addr, 6'h30);
        next_cycle();
        fetch_req = 1'b0;

        // reset during beat 2 abandons the burst
        refill_beat(1'b1, 1'b0, 6'h20);
        @(negedge clk);
        check("r_b1_gnt", refill_gnt, 1);
        next_cycle();
        refill_beat(1'b1, 1'b0, 6'h21);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        refill_beat(1'b0, 1'b0, 6'h00);
        fetch_req = 1'b1; fetch_addr = 6'h07;
        @(negedge clk);
        check("r_rvalid", fetch_rvalid, 0);
        check("r_fetch_gnt", fetch_gnt, 1);
        check("r_ram_addr", ram_addr, 6'h07);
        next_cycle();
        fetch_req = 1'b0;

        // back-to-back single-beat refills with fetch waiting
        next_cycle();
        fetch_req = 1'b1; fetch_addr = 6'h3F;
        refill_beat(1'b1, 1'b1, 6'h01);
        for (int i = 0; i < 6; i++) begin
            logic exp_f;
            exp_f = AGING && (i == 3);
            @(negedge clk);
            check($sformatf("age_fetch_gnt%0d", i), fetch_gnt, exp_f);
            check($sformatf("age_refill_gnt%0d", i), refill_gnt, !exp_f);
            next_cycle();
        end
        fetch_req = 1'b0;
        refill_beat(1'b0, 1'b0, 6'h00);
        @(negedge clk);
        check("end_ram_req", ram_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1);
    end
endmodule
